// File: rtl/stack_ctrl.sv
// Stack controller: LIFO command front-end that drives an external single-port RAM
// which captures address and write data on the falling clock edge.
module stack_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_byte,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we_n,
  output logic                  mem_byteena,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_RSP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [2:0] state;
  logic [1:0] op_r;

  assign cmd_ready = (state == S_IDLE);
  assign empty     = (count == '0);
  assign full      = (count == DEPTH);

  // The RAM-facing registers double as the captured command data, so they only
  // change when a command actually needs the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_r        <= OP_PUSH;
      count       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      mem_we_n    <= 1'b1;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_byteena <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_r <= cmd_op;
            case (cmd_op)
              OP_PUSH: begin
                if (full) begin
                  state     <= S_DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state       <= S_WR;
                  mem_addr    <= count[ADDR_WIDTH-1:0];
                  mem_data    <= cmd_data;
                  mem_byteena <= ~cmd_byte;
                  mem_we_n    <= 1'b0;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  state     <= S_DONE;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end else begin
                  state    <= S_RD;
                  mem_addr <= count[ADDR_WIDTH-1:0] - ADDR_ONE;
                end
              end
              OP_CLEAR: begin
                state     <= S_DONE;
                count     <= '0;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
              end
            endcase
          end
        end
        S_WR: begin
          state     <= S_DONE;
          count     <= count + CNT_ONE;
          mem_we_n  <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        // mem_q already reflects the address captured on the falling edge in RD
        S_RD: begin
          state     <= S_RSP;
          rsp_data  <= mem_q;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        S_RSP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (op_r == OP_POP) count <= count - CNT_ONE;
        end
        S_DONE: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          mem_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule
